// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider.
// State encodings, counter width and latency helpers.
package div_unit_pkg;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;

    function automatic int div_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    function automatic int div_latency(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring division iteration.
// Shifts {r,q} left by one and conditionally subtracts b.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] diff;
    logic           ge;

    // Shift, compare and restore. A set top bit of r_i means the
    // shifted value exceeds any divisor, so it forces the subtract.
    always_comb begin
        r_sh = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
        diff = r_sh - {1'b0, b_i};
        ge   = r_i[WIDTH] | (r_sh >= {1'b0, b_i});
        r_o  = ge ? diff : r_sh;
        q_o  = {q_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Quotient feeds LO, remainder feeds HI.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iDividend,
    input  logic [WIDTH-1:0] iDivisor,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oQuotient,
    output logic [WIDTH-1:0] oRemainder
);

    localparam int CNT_W = div_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             divz_q, divz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] qout_q, qout_d;
    logic [WIDTH-1:0] rout_q, rout_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   r_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] q_fix, r_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i (r_q),
        .q_i (quo_q),
        .b_i (b_q),
        .r_o (r_nx),
        .q_o (q_nx)
    );

    // Operand magnitudes; |MIN_INT| still fits in WIDTH unsigned bits.
    always_comb begin
        a_neg = iSigned & iDividend[WIDTH-1];
        b_neg = iSigned & iDivisor[WIDTH-1];
        a_mag = a_neg ? -iDividend : iDividend;
        b_mag = b_neg ? -iDivisor : iDivisor;
    end

    // Sign fix-up; divide by zero forces an all-ones quotient while the
    // remainder naturally equals the original dividend.
    always_comb begin
        q_fix = qneg_q ? -quo_q : quo_q;
        if (divz_q) begin
            q_fix = '1;
        end
        r_fix = rneg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_d     = r_q;
        quo_d   = quo_q;
        b_d     = b_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        divz_d  = divz_q;
        qout_d  = qout_q;
        rout_d  = rout_q;
        done_d  = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (iStart) begin
                    state_d = DIV_RUN;
                    count_d = '0;
                    r_d     = '0;
                    quo_d   = a_mag;
                    b_d     = b_mag;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    divz_d  = (iDivisor == '0);
                end
            end
            DIV_RUN: begin
                r_d     = r_nx;
                quo_d   = q_nx;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                qout_d  = q_fix;
                rout_d  = r_fix;
                done_d  = 1'b1;
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation and clears results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            divz_q  <= 1'b0;
            done_q  <= 1'b0;
            qout_q  <= '0;
            rout_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            divz_q  <= divz_d;
            done_q  <= done_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
        end
    end

    // Busy is decoded straight from state so hazard logic sees it early.
    always_comb begin
        oBusy      = (state_q == DIV_RUN) || (state_q == DIV_FIX);
        oDone      = done_q;
        oQuotient  = qout_q;
        oRemainder = rout_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit.
// Hand-computed vectors with immediate assertions.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = 32;
    localparam int LAT = div_latency(W);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         iStart = 1'b0;
    logic         iSigned = 1'b0;
    logic [W-1:0] iDividend = '0;
    logic [W-1:0] iDivisor = '0;
    logic         oBusy;
    logic         oDone;
    logic [W-1:0] oQuotient;
    logic [W-1:0] oRemainder;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .iStart     (iStart),
        .iSigned    (iSigned),
        .iDividend  (iDividend),
        .iDivisor   (iDivisor),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oQuotient  (oQuotient),
        .oRemainder (oRemainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge; holds iStart across one edge.
    task automatic pulse_start(input logic s, input logic [W-1:0] a,
                               input logic [W-1:0] b);
        iStart = 1'b1;
        iSigned = s;
        iDividend = a;
        iDivisor = b;
        @(posedge clk);
        #1;
        iStart = 1'b0;
    endtask

    // Counts edges (start edge included) until oDone, bounded.
    task automatic wait_done(input int from, input int bfrom,
                             output int lat, output int bcnt);
        lat = from;
        bcnt = bfrom;
        while (!oDone && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (oBusy) bcnt++;
        end
    endtask

    task automatic run_div(input string tag, input logic s,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er);
        int lat;
        int bcnt;
        pulse_start(s, a, b);
        wait_done(1, oBusy ? 1 : 0, lat, bcnt);
        check({tag, "_q"}, oQuotient, eq);
        check({tag, "_r"}, oRemainder, er);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_busy"}, bcnt, W + 1);
    endtask

    initial begin
        int lat;
        int bcnt;

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        check("rst_done", {31'd0, oDone}, 32'd0);
        check("rst_q", oQuotient, 32'd0);
        check("rst_r", oRemainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        @(posedge clk);
        #1;
        check("done_pulse", {31'd0, oDone}, 32'd0);
        check("hold_q", oQuotient, 32'd14);

        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
                32'hFFFFFFFD, 32'd1);
        run_div("divu_z", 1'b0, 32'h12345678, 32'd0,
                32'hFFFFFFFF, 32'h12345678);
        run_div("div_m5_z", 1'b1, 32'hFFFFFFFB, 32'd0,
                32'hFFFFFFFF, 32'hFFFFFFFB);
        run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
                32'h80000000, 32'd0);
        run_div("divu_max", 1'b0, 32'hFFFFFFFF, 32'd1,
                32'hFFFFFFFF, 32'd0);

        pulse_start(1'b0, 32'd100, 32'd7);
        check("acc_hold_q", oQuotient, 32'hFFFFFFFF);
        lat = 1;
        bcnt = 1;
        repeat (8) begin
            @(posedge clk);
            #1;
            lat++;
            if (oBusy) bcnt++;
        end
        pulse_start(1'b0, 32'd9, 32'd3);
        lat++;
        if (oBusy) bcnt++;
        wait_done(lat, bcnt, lat, bcnt);
        check("ign_q", oQuotient, 32'd14);
        check("ign_r", oRemainder, 32'd2);
        check("ign_lat", lat, LAT);
        check("ign_busy", bcnt, W + 1);

        pulse_start(1'b0, 32'd9, 32'd3);
        check("odone_acc_busy", {31'd0, oBusy}, 32'd1);
        check("odone_acc_q", oQuotient, 32'd14);
        wait_done(1, 1, lat, bcnt);
        check("b2b_q", oQuotient, 32'd3);
        check("b2b_r", oRemainder, 32'd0);
        check("b2b_lat", lat, LAT);

        pulse_start(1'b0, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, oBusy}, 32'd0);
        check("mid_rst_q", oQuotient, 32'd0);
        check("mid_rst_r", oRemainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (oDone || oBusy) bcnt++;
        end
        check("no_done_after_rst", bcnt, 0);

        run_div("after_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
